// File: rtl/rns_to_int_converter.sv
// Multi-cycle RNS {256,129} -> integer reverse converter using mixed-radix CRT.
// X = r256 + 256*(((r129 - r256) * 64) mod 129); the x64 is six mod-129 doublings.
module rns_to_int_converter #(
   parameter int DW        = 16,
   parameter int M_LO      = 129,
   parameter int INV_SHIFT = 6
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_rns,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_int,
   output logic          out_err
);

   localparam logic [8:0] M9   = 9'(M_LO);
   localparam logic [2:0] LAST = 3'(INV_SHIFT - 1);

   typedef enum logic [1:0] {IDLE, DIFF, MUL, DONE} state_t;

   state_t     state, state_nxt;
   logic [7:0] r256, r129, t;
   logic       err;
   logic [2:0] cnt;

   logic [7:0] a;
   logic [8:0] diff, diff_mod, dbl, dbl_mod;

   assign in_ready = (state == IDLE);

   // r256 reduced into [0,128] so the 9-bit difference stays within one modulus of range
   assign a        = ({1'b0, r256} >= M9) ? 8'(({1'b0, r256} - M9)) : r256;
   assign diff     = {1'b0, r129} - {1'b0, a};
   assign diff_mod = diff[8] ? diff + M9 : diff;
   assign dbl      = {t, 1'b0};
   assign dbl_mod  = (dbl >= M9) ? dbl - M9 : dbl;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (in_valid)              state_nxt = DIFF;
         DIFF:                            state_nxt = MUL;
         MUL:  if (cnt == LAST)           state_nxt = DONE;
         DONE: if (out_valid && out_ready) state_nxt = IDLE;
         default:                         state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r256      <= '0;
         r129      <= '0;
         err       <= 1'b0;
         t         <= '0;
         cnt       <= '0;
         out_valid <= 1'b0;
         out_int   <= '0;
         out_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               r256 <= in_rns[15:8];
               r129 <= in_rns[7:0];
               err  <= ({1'b0, in_rns[7:0]} >= M9);
            end
            DIFF: begin
               t   <= err ? 8'h00 : diff_mod[7:0];
               cnt <= '0;
            end
            MUL: begin
               t   <= dbl_mod[7:0];
               cnt <= cnt + 3'd1;
            end
            DONE: begin
               // first DONE cycle registers the result; afterwards hold until handshake
               if (!out_valid) begin
                  out_valid <= 1'b1;
                  out_int   <= err ? '0 : ({t, 8'h00} + {8'h00, r256});
                  out_err   <= err;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_rns_to_int_converter.sv
// Directed bench for rns_to_int_converter: latency, boundaries, strided CRT sweep,
// backpressure hold, illegal residue and mid-conversion reset.
module tb_rns_to_int_converter;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_rns;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_int;
   logic        out_err;

   int n_chk  = 0;
   int n_pass = 0;

   rns_to_int_converter dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_rns    (in_rns),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_int   (out_int),
      .out_err   (out_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic convert(input logic [15:0] rns, input logic [15:0] exp_int,
                          input logic exp_err, input string tag);
      int lat;
      chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
      in_rns = rns; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_valid(lat);
      chk({tag, " latency"}, 32'(lat), 32'd8);
      chk({tag, " out_int"}, 32'(out_int), 32'(exp_int));
      chk({tag, " out_err"}, 32'(out_err), 32'(exp_err));
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, " drop"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      int lat;
      logic [15:0] v;

      reset = 1'b0; in_valid = 1'b0; in_rns = '0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      chk("rst in_ready",  32'(in_ready),  32'd1);
      chk("rst out_valid", 32'(out_valid), 32'd0);
      chk("rst out_int",   32'(out_int),   32'd0);
      chk("rst out_err",   32'(out_err),   32'd0);
      @(posedge clk); #1;

      // (232,97): a=103, t=-6+129=123, 123*64 mod 129 = 3 -> 3*256+232
      convert(16'hE861, 16'd1000, 1'b0, "e861");
      convert(16'h0000, 16'd0,    1'b0, "zero");
      convert(16'hFF80, 16'h80FF, 1'b0, "max");
      convert(16'h0180, 16'd257,  1'b0, "x257");
      convert(16'h0101, 16'd1,    1'b0, "x1");
      convert(16'h05C8, 16'd0,    1'b1, "err");

      // strided sweep: residues generated from X, result must be X
      for (int x = 0; x < 33024; x += 167) begin
         v = {8'(x % 256), 8'(x % 129)};
         convert(v, 16'(x), 1'b0, "sweep");
      end
      convert({8'(33022 % 256), 8'(33022 % 129)}, 16'd33022, 1'b0, "sweep_hi");

      // backpressure hold with a stray input pulse
      in_rns = 16'hE861; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_valid(lat);
      chk("hold latency", 32'(lat), 32'd8);
      for (int i = 0; i < 5; i++) begin
         in_valid = (i == 1);
         in_rns   = 16'h0101;
         @(posedge clk); #1;
         chk("hold out_valid", 32'(out_valid), 32'd1);
         chk("hold out_int",   32'(out_int),   32'd1000);
         chk("hold in_ready",  32'(in_ready),  32'd0);
      end
      // handshake with in_valid high: input must not be taken
      in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b0;
      chk("release out_valid", 32'(out_valid), 32'd0);
      chk("release in_ready",  32'(in_ready),  32'd1);
      repeat (3) @(posedge clk);
      #1;
      chk("idle in_ready",  32'(in_ready),  32'd1);
      chk("idle out_valid", 32'(out_valid), 32'd0);
      chk("idle out_int",   32'(out_int),   32'd1000);

      // reset four cycles into a conversion
      in_rns = 16'hFF80; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      chk("abort in_ready",  32'(in_ready),  32'd1);
      chk("abort out_valid", 32'(out_valid), 32'd0);
      chk("abort out_int",   32'(out_int),   32'd0);
      chk("abort out_err",   32'(out_err),   32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (out_valid) chk("abort pulse", 32'(out_valid), 32'd0);
      end
      convert(16'hE861, 16'd1000, 1'b0, "post_rst");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
